// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// mux selects, ALU functions and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [1:0] ImmRot8   = 2'b00;
    localparam logic [1:0] ImmZext12 = 2'b01;
    localparam logic [1:0] ImmBr24   = 2'b10;

    localparam logic [1:0] SrcARd1    = 2'b00;
    localparam logic [1:0] SrcAPc     = 2'b01;
    localparam logic [1:0] SrcAAluOut = 2'b10;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBExt  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [3:0] CondEq = 4'h0;
    localparam logic [3:0] CondNe = 4'h1;
    localparam logic [3:0] CondCs = 4'h2;
    localparam logic [3:0] CondCc = 4'h3;
    localparam logic [3:0] CondMi = 4'h4;
    localparam logic [3:0] CondPl = 4'h5;
    localparam logic [3:0] CondVs = 4'h6;
    localparam logic [3:0] CondVc = 4'h7;
    localparam logic [3:0] CondHi = 4'h8;
    localparam logic [3:0] CondLs = 4'h9;
    localparam logic [3:0] CondGe = 4'hA;
    localparam logic [3:0] CondLt = 4'hB;
    localparam logic [3:0] CondGt = 4'hC;
    localparam logic [3:0] CondLe = 4'hD;
    localparam logic [3:0] CondAl = 4'hE;

endpackage

// File: rtl/cond_logic.sv
// NZCV status register, condition evaluation and gating of architectural
// writes. The condition is captured once per instruction in DECODE.
module cond_logic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       decode,
    input  logic       exec,
    input  logic       fetch,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       pcs,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write
);

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       cond_ex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            CondEq: cond_ex = z;
            CondNe: cond_ex = ~z;
            CondCs: cond_ex = c;
            CondCc: cond_ex = ~c;
            CondMi: cond_ex = n;
            CondPl: cond_ex = ~n;
            CondVs: cond_ex = v;
            CondVc: cond_ex = ~v;
            CondHi: cond_ex = c & ~z;
            CondLs: cond_ex = ~c | z;
            CondGe: cond_ex = (n == v);
            CondLt: cond_ex = (n != v);
            CondGt: cond_ex = ~z & (n == v);
            CondLe: cond_ex = z | (n != v);
            CondAl: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flags written in EXECx use the condition latched in DECODE, so the
    // following ALUWB is gated by the pre-update flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (decode) begin
                cond_ex_q <= cond_ex;
            end
            if (exec && cond_ex_q) begin
                if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
                if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    assign reg_write = reg_w & cond_ex_q;
    assign mem_write = mem_w & cond_ex_q;
    assign pc_write  = fetch | (pcs & cond_ex_q);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle ARM core: sequences fetch, decode,
// execute and writeback and decodes the held instruction fields.
module multicycle_ctrl
    import arm_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    state_e     state_q, state_d;
    logic       ir_write, adr_src, alu_op, reg_w, mem_w, branch;
    logic [1:0] src_a, src_b, res_src, alu_ctl, dec_ctl, flag_w;
    logic       no_write, known_op, arith_op;
    logic       reg_write, mem_write, pc_write, pcs;

    always_ff @(posedge CLK) begin
        if (!RESETn) state_q <= StFetch;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = StFetch;
        ir_write = 1'b0;
        adr_src  = 1'b0;
        src_a    = SrcARd1;
        src_b    = SrcBRd2;
        res_src  = ResAluOut;
        alu_op   = 1'b0;
        reg_w    = 1'b0;
        mem_w    = 1'b0;
        branch   = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write = 1'b1;
                src_a    = SrcAPc;
                src_b    = SrcBFour;
                res_src  = ResAluResult;
                state_d  = StDecode;
            end
            StDecode: begin
                src_a   = SrcAPc;
                src_b   = SrcBFour;
                res_src = ResAluResult;
                case (Op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                src_b   = SrcBExt;
                state_d = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                adr_src = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                res_src = ResData;
                reg_w   = 1'b1;
            end
            StMemWr: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            StExecR: begin
                alu_op  = 1'b1;
                state_d = StAluWb;
            end
            StExecI: begin
                src_b   = SrcBExt;
                alu_op  = 1'b1;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_w = ~no_write;
            end
            StBranch: begin
                src_a   = SrcAAluOut;
                src_b   = SrcBExt;
                res_src = ResAluResult;
                branch  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Unrecognised data-processing codes run as ADD but suppress all writes.
    always_comb begin
        dec_ctl  = AluAdd;
        known_op = 1'b1;
        arith_op = 1'b0;
        no_write = 1'b0;
        case (Funct[4:1])
            4'b0100: begin dec_ctl = AluAdd; arith_op = 1'b1; end
            4'b0010: begin dec_ctl = AluSub; arith_op = 1'b1; end
            4'b0000: dec_ctl = AluAnd;
            4'b1100: dec_ctl = AluOrr;
            4'b1010: begin dec_ctl = AluSub; arith_op = 1'b1; no_write = 1'b1; end
            default: begin dec_ctl = AluAdd; known_op = 1'b0; no_write = 1'b1; end
        endcase
    end

    always_comb begin
        alu_ctl = AluAdd;
        flag_w  = 2'b00;
        if (state_q == StMemAdr) begin
            alu_ctl = Funct[3] ? AluAdd : AluSub;
        end else if (alu_op) begin
            alu_ctl = dec_ctl;
            flag_w  = {Funct[0] & known_op, Funct[0] & arith_op};
        end
    end

    assign pcs = branch | (reg_w & (Rd == 4'd15));

    cond_logic u_cond_logic (
        .clk       (CLK),
        .resetn    (RESETn),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .decode    (state_q == StDecode),
        .exec      (alu_op),
        .fetch     (state_q == StFetch),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .pcs       (pcs),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .pc_write  (pc_write)
    );

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = 2'b00;
        State      = 4'd0;
        if (RESETn) begin
            PCWrite    = pc_write;
            MemWrite   = mem_write;
            RegWrite   = reg_write;
            IRWrite    = ir_write;
            AdrSrc     = adr_src;
            ALUSrcA    = src_a;
            ALUSrcB    = src_b;
            ResultSrc  = res_src;
            ImmSrc     = Op;
            RegSrc     = {Op == 2'b01, Op == 2'b10};
            ALUControl = alu_ctl;
            State      = state_q;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl: one record per clock cycle
// with hand-computed outputs, plus a reset-during-store sequence.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] State;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rstn;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  flags;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [3:0] cur_cond, cur_rd;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;

    multicycle_ctrl dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    always #5 CLK = ~CLK;

    // {PCW, MemW, RegW, IRW, AdrSrc, SrcA, SrcB, ResSrc, ImmSrc, RegSrc, ALUCtl, State}
    function automatic logic [20:0] mk(input logic pcw, input logic memw, input logic regw,
                                       input logic irw, input logic adr, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [1:0] rs,
                                       input logic [1:0] alu, input logic [3:0] st);
        return {pcw, memw, regw, irw, adr, sa, sb, res, imm, rs, alu, st};
    endfunction

    function automatic logic [20:0] f_fetch(input logic [1:0] imm, input logic [1:0] rs);
        return mk(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, imm, rs, 2'b00, 4'd0);
    endfunction

    function automatic logic [20:0] f_decode(input logic [1:0] imm, input logic [1:0] rs);
        return mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, imm, rs, 2'b00, 4'd1);
    endfunction

    task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r);
        cur_cond = c; cur_op = o; cur_funct = f; cur_rd = r;
    endtask

    task automatic row(input logic rstn, input logic [3:0] fl, input logic [20:0] e);
        vec_t v;
        v.rstn = rstn; v.cond = cur_cond; v.op = cur_op; v.funct = cur_funct;
        v.rd = cur_rd; v.flags = fl; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic logic [20:0] actual();
        return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ImmSrc, RegSrc, ALUControl, State};
    endfunction

    task automatic check(input string name, input logic [20:0] exp);
        checks++;
        if (actual() !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual(), exp);
        end
    endtask

    task automatic apply(input vec_t v);
        RESETn = v.rstn; Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd;
        ALUFlags = v.flags;
    endtask

    initial begin
        bit found;

        // Reset, then ADD immediate (AL, Rd=1)
        instr(4'hE, 2'b00, 6'b101000, 4'd1);
        row(0, 4'h0, 21'd0);
        row(0, 4'h0, 21'd0);
        row(1, 4'h0, f_fetch(2'b00, 2'b00));
        row(1, 4'h0, f_decode(2'b00, 2'b00));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7));
        row(1, 4'h0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd8));
        // SUBS reg producing Z=1, then BEQ taken
        instr(4'hE, 2'b00, 6'b000101, 4'd2);
        row(1, 4'h0, f_fetch(2'b00, 2'b00));
        row(1, 4'h0, f_decode(2'b00, 2'b00));
        row(1, 4'b0100, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd6));
        row(1, 4'h0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd8));
        instr(4'h0, 2'b10, 6'b100000, 4'd0);
        row(1, 4'h0, f_fetch(2'b10, 2'b01));
        row(1, 4'h0, f_decode(2'b10, 2'b01));
        row(1, 4'h0, mk(1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'd9));
        // SUBS producing Z=0, then BEQ not taken
        instr(4'hE, 2'b00, 6'b000101, 4'd4);
        row(1, 4'h0, f_fetch(2'b00, 2'b00));
        row(1, 4'h0, f_decode(2'b00, 2'b00));
        row(1, 4'b0000, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd6));
        row(1, 4'h0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd8));
        instr(4'h0, 2'b10, 6'b100000, 4'd0);
        row(1, 4'h0, f_fetch(2'b10, 2'b01));
        row(1, 4'h0, f_decode(2'b10, 2'b01));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'd9));
        // LDR
        instr(4'hE, 2'b01, 6'b011001, 4'd5);
        row(1, 4'h0, f_fetch(2'b01, 2'b10));
        row(1, 4'h0, f_decode(2'b01, 2'b10));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 4'd2));
        row(1, 4'h0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 4'd3));
        row(1, 4'h0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 4'd4));
        // STR
        instr(4'hE, 2'b01, 6'b011000, 4'd6);
        row(1, 4'h0, f_fetch(2'b01, 2'b10));
        row(1, 4'h0, f_decode(2'b01, 2'b10));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 4'd2));
        row(1, 4'h0, mk(0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 4'd5));
        // CMP immediate setting N=1: no register write
        instr(4'hE, 2'b00, 6'b110101, 4'd0);
        row(1, 4'h0, f_fetch(2'b00, 2'b00));
        row(1, 4'h0, f_decode(2'b00, 2'b00));
        row(1, 4'b1000, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd8));
        // BMI taken shows the CMP updated N
        instr(4'h4, 2'b10, 6'b100000, 4'd0);
        row(1, 4'h0, f_fetch(2'b10, 2'b01));
        row(1, 4'h0, f_decode(2'b10, 2'b01));
        row(1, 4'h0, mk(1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'd9));
        // ADD to R15: PC and register write together
        instr(4'hE, 2'b00, 6'b101000, 4'd15);
        row(1, 4'h0, f_fetch(2'b00, 2'b00));
        row(1, 4'h0, f_decode(2'b00, 2'b00));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7));
        row(1, 4'h0, mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd8));
        // ADDMIS clears N in EXECI, yet its own ALUWB still writes
        instr(4'h4, 2'b00, 6'b101001, 4'd7);
        row(1, 4'h0, f_fetch(2'b00, 2'b00));
        row(1, 4'h0, f_decode(2'b00, 2'b00));
        row(1, 4'b0000, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7));
        row(1, 4'h0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd8));
        // BMI now not taken
        instr(4'h4, 2'b10, 6'b100000, 4'd0);
        row(1, 4'h0, f_fetch(2'b10, 2'b01));
        row(1, 4'h0, f_decode(2'b10, 2'b01));
        row(1, 4'h0, mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'd9));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge CLK);
            check($sformatf("row%0d", i), vecs[i].exp);
            @(posedge CLK);
            #1;
        end

        // Reset asserted during MEMWR of a store
        RESETn = 1'b1; Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd6;
        ALUFlags = 4'h0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge CLK);
            if (State == 4'd2) found = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_memadr: got state %0d expected 2 within 8 cycles", State);
        end
        @(posedge CLK);
        #1;
        RESETn = 1'b0;
        @(negedge CLK);
        check("reset_in_memwr", 21'd0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        @(negedge CLK);
        check("fetch_after_reset", f_fetch(2'b01, 2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle ARM core.
- Sequences the shared datapath (PC/IR registers, register file, Extend, ALU, unified memory) through fetch, decode, execute and writeback.
- Decodes Op/Funct/Rd from the instruction register into mux selects, ALU function and ImmSrc for the immediate extender.
- Holds the NZCV status flags and gates all architectural writes with the condition check.

Parameters:
None. All encodings are fixed in the package.

Ports:
CLK  in  1  system clock, rising edge
RESETn  in  1  synchronous reset, active-low
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  ALU NZCV result {N,Z,C,V}
PCWrite  out  1  PC register enable
MemWrite  out  1  memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
ALUSrcA  out  2  00=RD1, 01=PC, 10=ALUOut
ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  Extend mode: 00=rotated imm8, 01=zero-extended imm12, 10=branch imm24
RegSrc  out  2  register-file address selects
ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
State  out  4  current FSM state (debug)

Behaviour:
- Reset: RESETn is sampled low at a CLK rise. State<=FETCH, Flags<=0000, CondExReg<=0. While RESETn=0 every output is forced to 0.
- Outputs are Moore: decoded combinationally from state plus the held instruction fields. No added latency.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional). Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. CondExReg<=CondEx at the end of this cycle. Next state:
  - Op=01 -> MEMADR
  - Op=00 and Funct[5]=0 -> EXECR
  - Op=00 and Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH (undefined; executes as a NOP)
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD if Funct[3]=1 else SUB. Next state: MEMRD if Funct[0]=1 else MEMWR.
- MEMRD: AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state: FETCH.
- MEMWR: AdrSrc=1, MemW=1. Next state: FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next state: ALUWB.
- EXECI: same as EXECR but ALUSrcB=01. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegW=1 unless NoWrite. Next state: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1. Next state: FETCH.
- Decode with ALUOp=1, on Funct[4:1]:
  - 0100 ADD -> 00
  - 0010 SUB -> 01
  - 0000 AND -> 10
  - 1100 ORR -> 11
  - 1010 CMP -> 01 with NoWrite=1
  - any other code -> ADD, with no register or flag write
- ALUOp=0 gives ADD, except in MEMADR as stated above.
- FlagW[1] (N,Z) = Funct[0]. FlagW[0] (C,V) = Funct[0] and the op is ADD, SUB or CMP.
- Static selects: ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
- CondEx: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 gives 0.
- Write gating:
  - RegWrite = RegW & CondExReg
  - MemWrite = MemW & CondExReg
  - PCWrite = FETCH | (PCS & CondExReg), where PCS = Branch | (RegW & Rd==15)
- Flag update: at the end of EXECR/EXECI, when CondExReg=1, NZ<=ALUFlags[3:2] if FlagW[1] and CV<=ALUFlags[1:0] if FlagW[0]. Flags are never written in other states.
- CondExReg is latched in DECODE, so a flag update in EXECx does not alter gating of the following ALUWB.
- Reset asserted in any state returns to FETCH on the next edge. Partial writes are not completed.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH (4-bit)
  - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc constants
  - cond-code constants
- One sub-module, cond_logic, holds the NZCV register, the CondEx evaluation, CondExReg and the write gating.

Test Plan:
- Reset: RESETn=0 for 2 cycles -> all outputs 0, Flags=0000. Release -> State=FETCH with IRWrite=1 and PCWrite=1.
- ADD immediate (Cond=1110, Op=00, Funct=101000) -> states FETCH, DECODE, EXECI, ALUWB, FETCH. In EXECI: ALUSrcB=01, ALUControl=00, ImmSrc=00. In ALUWB: RegWrite=1.
- SUBS then BEQ:
  - SUBS with ALUFlags=0100 -> Z=1 after EXECR.
  - BEQ (Cond=0000, Op=10) -> PCWrite=1 in BRANCH, ImmSrc=10.
  - Repeat with Z=0 -> PCWrite=0 in BRANCH.
- LDR (Op=01, Funct=011001) -> path through MEMADR, MEMRD, MEMWB with AdrSrc=1 and ResultSrc=01, RegWrite=1 in MEMWB.
- STR (Funct=011000) -> MemWrite=1 only in MEMWR.
- CMP (Funct=110101) -> RegWrite=0 in ALUWB and flags updated. ADD with Rd=15 -> PCWrite=1 and RegWrite=1 in ALUWB.
- Reset mid-operation: RESETn=0 during MEMWR -> MemWrite=0 that cycle and State=FETCH after the edge.
